// File: rtl/seq_divider_8bit_pkg.sv
// Shared constants and types for the sequential restoring divider.
//   DEFAULT_WIDTH : default operand width W (dividend is 2W bits)
//   CNT_W         : iteration counter width for the default width
//   state_e       : controller state encoding
package seq_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider_8bit_if.sv
// Start/busy/done request-result bundle for seq_divider_8bit.
//   start, dividend, divisor          : request (master -> slave)
//   busy, done, quotient, remainder,
//   div_zero, overflow                : status/result (slave -> master)
interface seq_divider_8bit_if #(
  parameter int unsigned WIDTH = 8
);

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );

endinterface

// File: rtl/seq_divider_8bit_div_step.sv
// One combinational restoring shift-subtract stage.
//   i_r       : current partial remainder (always < divisor, so W bits suffice)
//   i_d_msb   : next dividend bit shifted in
//   i_divisor : divisor
//   o_r       : next partial remainder
//   o_q_bit   : quotient bit produced by this stage
module div_step
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_d_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_r,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_shift = {i_r, i_d_msb};
    w_trial = w_shift - {1'b0, i_divisor};
    // Trial result is non-negative exactly when its top bit is clear.
    o_q_bit = ~w_trial[WIDTH];
    o_r     = o_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential restoring radix-2 divider: 2W-bit dividend / W-bit divisor.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : request/result bundle (slave side)
// Normal division completes W RUN iterations; divide-by-zero and quotient
// overflow are detected in CHECK and finish immediately with saturated results.
module seq_divider_8bit
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  seq_divider_8bit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             r_state;
  logic [2*WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  // Partial remainder R: its top bit is provably zero between steps, so only W bits are kept.
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_d;
  // Holds the first W-1 quotient bits; the last one comes straight from the step.
  logic [WIDTH-2:0]   r_qacc;
  logic [CntW-1:0]    r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_zero;
  logic               r_overflow;

  logic [WIDTH-1:0]   w_r_next;
  logic               w_q_bit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_r       (r_rem),
    .i_d_msb   (r_d[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_r       (w_r_next),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_d         <= '0;
      r_qacc      <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_dividend <= bus.dividend;
            r_divisor  <= bus.divisor;
            r_div_zero <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StCheck;
          end
        end

        StCheck: begin
          if (r_divisor == '0) begin
            r_div_zero  <= 1'b1;
            r_quotient  <= '1;
            r_remainder <= r_dividend[WIDTH-1:0];
            r_done      <= 1'b1;
            r_state     <= StDone;
          end else if (r_dividend[2*WIDTH-1:WIDTH] >= r_divisor) begin
            // Quotient would need more than W bits.
            r_overflow  <= 1'b1;
            r_quotient  <= '1;
            r_remainder <= '1;
            r_done      <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_rem   <= r_dividend[2*WIDTH-1:WIDTH];
            r_d     <= r_dividend[WIDTH-1:0];
            r_qacc  <= '0;
            r_cnt   <= '0;
            r_state <= StRun;
          end
        end

        StRun: begin
          r_rem  <= w_r_next;
          r_d    <= {r_d[WIDTH-2:0], 1'b0};
          r_qacc <= {r_qacc[WIDTH-3:0], w_q_bit};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CntW'(WIDTH - 1)) begin
            r_quotient  <= {r_qacc, w_q_bit};
            r_remainder <= w_r_next;
            r_done      <= 1'b1;
            r_state     <= StDone;
          end
        end

        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.div_zero  = r_div_zero;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench for seq_divider_8bit: directed vector table, hand-written
// handshake/reset sequences, multiplier round trips and a behavioural / % model.
module tb_seq_divider_8bit;

  logic clk;
  logic rst;

  seq_divider_8bit_if #(.WIDTH(8)) bus_if ();

  seq_divider_8bit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge one cycle after done.
  task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs, output int lat,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov);
    bus_if.dividend = dvd;
    bus_if.divisor  = dvs;
    bus_if.start    = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus_if.start = 1'b0;
    while (bus_if.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q  = bus_if.quotient;
    r  = bus_if.remainder;
    dz = bus_if.div_zero;
    ov = bus_if.overflow;
    if (lat >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no done within %0d cycles for %0d/%0d", lat, dvd, dvs);
    end
    @(negedge clk);
    chk("done_single_pulse", {31'd0, bus_if.done}, 32'd0);
  endtask

  int          lat;
  logic [7:0]  q, r;
  logic        dz, ov;
  int          done_cnt;

  initial begin
    bus_if.start    = 1'b0;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_done", {31'd0, bus_if.done}, 32'd0);
    chk("rst_quotient", {24'd0, bus_if.quotient}, 32'd0);
    chk("rst_remainder", {24'd0, bus_if.remainder}, 32'd0);
    chk("rst_div_zero", {31'd0, bus_if.div_zero}, 32'd0);
    chk("rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 12/4 by hand: busy from the cycle after the start edge through the done cycle.
    bus_if.dividend = 16'd12;
    bus_if.divisor  = 8'd4;
    bus_if.start    = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b0;
      chk($sformatf("small_busy_c%0d", c), {31'd0, bus_if.busy}, 32'd1);
      chk($sformatf("small_done_c%0d", c), {31'd0, bus_if.done}, (c == 10) ? 32'd1 : 32'd0);
    end
    chk("small_quotient", {24'd0, bus_if.quotient}, 32'd3);
    chk("small_remainder", {24'd0, bus_if.remainder}, 32'd0);
    chk("small_flags", {30'd0, bus_if.div_zero, bus_if.overflow}, 32'd0);
    @(negedge clk);
    chk("small_busy_after", {31'd0, bus_if.busy}, 32'd0);
    chk("small_done_after", {31'd0, bus_if.done}, 32'd0);

    // Directed vector table.
    vecs.push_back('{16'd12,    8'd4,   8'd3,    8'd0,    1'b0, 1'b0, 10});
    vecs.push_back('{16'd65025, 8'd255, 8'd255,  8'd0,    1'b0, 1'b0, 10});
    vecs.push_back('{16'd1000,  8'd7,   8'd142,  8'd6,    1'b0, 1'b0, 10});
    vecs.push_back('{16'h1234,  8'd0,   8'hFF,   8'h34,   1'b1, 1'b0, 2});
    vecs.push_back('{16'h0100,  8'd1,   8'hFF,   8'hFF,   1'b0, 1'b1, 2});
    vecs.push_back('{16'hFFFF,  8'hFF,  8'hFF,   8'hFF,   1'b0, 1'b1, 2});
    vecs.push_back('{16'h00FE,  8'hFF,  8'd0,    8'hFE,   1'b0, 1'b0, 10});
    vecs.push_back('{16'h0000,  8'd0,   8'hFF,   8'h00,   1'b1, 1'b0, 2});
    vecs.push_back('{16'h7FFF,  8'h80,  8'hFF,   8'h7F,   1'b0, 1'b0, 10});
    for (int i = 0; i < vecs.size(); i++) begin
      run_div(vecs[i].dvd, vecs[i].dvs, lat, q, r, dz, ov);
      chk($sformatf("vec%0d_quotient", i), {24'd0, q}, {24'd0, vecs[i].q});
      chk($sformatf("vec%0d_remainder", i), {24'd0, r}, {24'd0, vecs[i].r});
      chk($sformatf("vec%0d_div_zero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
      chk($sformatf("vec%0d_overflow", i), {31'd0, ov}, {31'd0, vecs[i].ov});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Start pulsed 3 cycles into a busy division must be ignored.
    bus_if.dividend = 16'd1000;
    bus_if.divisor  = 8'd7;
    bus_if.start    = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus_if.start = (c == 3);
      if (c == 3) begin
        bus_if.dividend = 16'd12;
        bus_if.divisor  = 8'd4;
      end
      if (bus_if.done === 1'b1) begin
        done_cnt++;
        chk("busy_start_done_cycle", c, 32'd10);
        chk("busy_start_quotient", {24'd0, bus_if.quotient}, 32'd142);
        chk("busy_start_remainder", {24'd0, bus_if.remainder}, 32'd6);
      end
    end
    chk("busy_start_done_count", done_cnt, 32'd1);
    chk("busy_start_held_q", {24'd0, bus_if.quotient}, 32'd142);

    // Reset during RUN iteration 4 aborts with everything cleared and no done.
    bus_if.dividend = 16'd1000;
    bus_if.divisor  = 8'd7;
    bus_if.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("abort_done", {31'd0, bus_if.done}, 32'd0);
    chk("abort_quotient", {24'd0, bus_if.quotient}, 32'd0);
    chk("abort_remainder", {24'd0, bus_if.remainder}, 32'd0);
    chk("abort_flags", {30'd0, bus_if.div_zero, bus_if.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 32'd0);
    run_div(16'd100, 8'd9, lat, q, r, dz, ov);
    chk("after_abort_quotient", {24'd0, q}, 32'd11);
    chk("after_abort_remainder", {24'd0, r}, 32'd1);
    chk("after_abort_flags", {30'd0, dz, ov}, 32'd0);

    // Round trip against multiplier products.
    for (int i = 0; i < 500; i++) begin
      logic [7:0]  a, b;
      logic [15:0] p;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      p = 16'(a) * 16'(b);
      run_div(p, b, lat, q, r, dz, ov);
      chk($sformatf("roundtrip_%0d_%0d", a, b), {14'd0, q, r, dz, ov}, {14'd0, a, 8'd0, 2'b00});
    end

    // Random operands against a behavioural model including both flag rules.
    for (int i = 0; i < 500; i++) begin
      logic [15:0] dvd;
      logic [7:0]  dvs, eq, er;
      logic        edz, eov;
      dvd = 16'($urandom);
      dvs = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (i % 3 == 0) dvd[15:8] = 8'($urandom_range(0, 31));
      if (dvs == 8'd0) begin
        eq = 8'hFF; er = dvd[7:0]; edz = 1'b1; eov = 1'b0;
      end else if (dvd[15:8] >= dvs) begin
        eq = 8'hFF; er = 8'hFF; edz = 1'b0; eov = 1'b1;
      end else begin
        eq = 8'(dvd / 16'(dvs)); er = 8'(dvd % 16'(dvs)); edz = 1'b0; eov = 1'b0;
      end
      run_div(dvd, dvs, lat, q, r, dz, ov);
      chk($sformatf("model_%0d_%0d", dvd, dvs), {14'd0, q, r, dz, ov},
          {14'd0, eq, er, edz, eov});
      chk($sformatf("model_lat_%0d_%0d", dvd, dvs), lat, (edz | eov) ? 32'd2 : 32'd10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
